// File: rtl/car_request_detector.sv
// car_request_detector: turns the raw side-road loop sensor into the car
// request C for the traffic light controller. The sensor is synchronised and
// debounced, arrivals are counted, a sensor stuck high is flagged, and a small
// FSM holds the request until the side road has been served.
module car_request_detector #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STUCK_CYCLES    = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_raw,
  input  logic [1:0] nitkRoadLights,
  input  logic       count_clr,
  output logic       C,
  output logic [7:0] car_count,
  output logic       stuck_fault
);

  localparam int DebW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int StuckW = $clog2(STUCK_CYCLES + 1);

  localparam logic [DebW-1:0]   DebOne    = DebW'(1);
  localparam logic [DebW-1:0]   DebLast   = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [StuckW-1:0] StuckOne  = StuckW'(1);
  localparam logic [StuckW-1:0] StuckMax  = StuckW'(STUCK_CYCLES);
  localparam logic [StuckW-1:0] StuckLast = StuckW'(STUCK_CYCLES - 1);

  localparam logic [1:0] LightGreen = 2'b10;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StServe = 2'd2
  } state_t;

  logic              r_sync1;
  logic              r_syncS;
  logic              r_d;
  logic              r_dPrev;
  logic [DebW-1:0]   r_debCnt;
  logic [StuckW-1:0] r_stuckCnt;
  logic              r_stuckFault;
  logic [7:0]        r_carCount;
  state_t            r_state;
  state_t            w_stateNext;
  logic              w_dRise;
  logic              w_green;
  logic              w_c;

  assign w_dRise = r_d & ~r_dPrev;
  assign w_green = (nitkRoadLights == LightGreen);

  // Two-flop synchroniser bringing the asynchronous loop sensor into clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_syncS <= 1'b0;
    end else begin
      r_sync1 <= sensor_raw;
      r_syncS <= r_sync1;
    end
  end

  // Debounce: the synchronised sensor must disagree with r_d for
  // DEBOUNCE_CYCLES consecutive cycles before r_d follows it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_d      <= 1'b0;
      r_debCnt <= '0;
    end else if (r_syncS != r_d) begin
      if (r_debCnt == DebLast) begin
        r_d      <= r_syncS;
        r_debCnt <= '0;
      end else begin
        r_debCnt <= r_debCnt + DebOne;
      end
    end else begin
      r_debCnt <= '0;
    end
  end

  // Previous debounced value, used to find the arrival (rising) edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dPrev <= 1'b0;
    end else begin
      r_dPrev <= r_d;
    end
  end

  // Stuck detection: time how long the debounced sensor stays high and raise
  // the fault once it has been high too long; any low cycle clears both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stuckCnt   <= '0;
      r_stuckFault <= 1'b0;
    end else if (!r_d) begin
      r_stuckCnt   <= '0;
      r_stuckFault <= 1'b0;
    end else if (r_stuckCnt != StuckMax) begin
      r_stuckCnt <= r_stuckCnt + StuckOne;
      if (r_stuckCnt == StuckLast) begin
        r_stuckFault <= 1'b1;
      end
    end
  end

  // Saturating arrival counter; a clear wins over a same-cycle arrival.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_carCount <= 8'd0;
    end else if (count_clr) begin
      r_carCount <= 8'd0;
    end else if (w_dRise && (r_carCount != 8'hFF)) begin
      r_carCount <= r_carCount + 8'd1;
    end
  end

  // Request FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state: a fault always forces IDLE; otherwise an arrival raises the
  // request, green serves it, and the end of green re-requests if a car is
  // still sitting on the loop.
  always_comb begin
    w_stateNext = r_state;
    if (r_stuckFault) begin
      w_stateNext = StIdle;
    end else begin
      case (r_state)
        StIdle:  if (w_dRise) w_stateNext = StWait;
        StWait:  if (w_green) w_stateNext = StServe;
        StServe: if (!w_green) w_stateNext = r_d ? StWait : StIdle;
        default: w_stateNext = StIdle;
      endcase
    end
  end

  // Request output decoded from the state; masked while the sensor is stuck
  // so a faulty loop can never hold the highway red.
  always_comb begin
    w_c = 1'b0;
    case (r_state)
      StWait:  w_c = 1'b1;
      StServe: w_c = r_d;
      default: w_c = 1'b0;
    endcase
    if (r_stuckFault) begin
      w_c = 1'b0;
    end
  end

  assign C           = w_c;
  assign car_count   = r_carCount;
  assign stuck_fault = r_stuckFault;

endmodule
